// File: rtl/mmio_serial_fifo.sv
// Memory-mapped serial port: core stores feed a TX FIFO, core loads drain an RX FIFO.
// Optional internal TX->RX loopback is built when SERIAL_LOOPBACK_EN is defined.
module mmio_serial_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0020,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              enable,
  input  logic              rw,
  input  logic [31:0]       addr,
  inout  wire logic [31:0]  data,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  logic [7:0] tx_mem_q [DEPTH];
  logic [7:0] tx_mem_d [DEPTH];
  logic [7:0] rx_mem_q [DEPTH];
  logic [7:0] rx_mem_d [DEPTH];
  ptr_t       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  ptr_t       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  cnt_t       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic       txdrop_q, txdrop_d;

  logic       hit_data, hit_stat;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop, loop_mv;
  logic       loop_on;
  logic [7:0] rx_in;
  logic [31:0] status, rd_data;
  logic       drive_en;
  logic       unused_data_hi;

  assign unused_data_hi = ^data[31:8];

  assign hit_data = enable && (addr == BASE_ADDR);
  assign hit_stat = enable && (addr == BASE_ADDR + 32'd1);

  assign tx_full  = (tx_cnt_q == cnt_t'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == cnt_t'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

`ifdef SERIAL_LOOPBACK_EN
  logic loop_q, loop_d;

  always_comb begin
    loop_d = loop_q;
    if (hit_stat && rw) loop_d = data[0];
  end

  always_ff @(posedge clk) begin
    if (!_reset) loop_q <= 1'b0;
    else         loop_q <= loop_d;
  end

  assign loop_on = loop_q;
`else
  assign loop_on = 1'b0;
`endif

  assign tx_byte  = tx_mem_q[tx_rd_q];
  assign tx_valid = _reset && !loop_on && !tx_empty;
  assign rx_ready = _reset && !loop_on && !rx_full;
  assign loop_mv  = loop_on && !tx_empty && !rx_full;

  // Full/empty are judged on pre-edge counts, so a same-cycle pop never rescues a write.
  always_comb begin
    tx_push = hit_data && rw && !tx_full;
    tx_pop  = (tx_valid && tx_ready) || loop_mv;
    rx_push = (rx_valid && rx_ready) || loop_mv;
    rx_pop  = hit_data && !rw && !rx_empty;
    rx_in   = loop_mv ? tx_byte : rx_byte;
  end

  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    txdrop_d = txdrop_q;

    if (tx_push) begin
      tx_mem_d[tx_wr_q] = data[7:0];
      tx_wr_d = tx_wr_q + ptr_t'(1);
    end
    if (tx_pop) tx_rd_d = tx_rd_q + ptr_t'(1);
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + cnt_t'(1);
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - cnt_t'(1);

    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_in;
      rx_wr_d = rx_wr_q + ptr_t'(1);
    end
    if (rx_pop) rx_rd_d = rx_rd_q + ptr_t'(1);
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + cnt_t'(1);
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - cnt_t'(1);

    if (hit_data && rw && tx_full) txdrop_d = 1'b1;
    else if (hit_stat && !rw)      txdrop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      txdrop_q <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      txdrop_q <= txdrop_d;
    end
  end

  // Storage needs no reset: zeroed counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_comb begin
    status = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 3'b000, loop_on,
              1'b0, txdrop_q, tx_full, !rx_empty};
    if (hit_stat)      rd_data = status;
    else if (rx_empty) rd_data = '1;
    else               rd_data = {24'h000000, rx_mem_q[rx_rd_q]};
  end

  assign drive_en = _reset && !rw && (hit_data || hit_stat);
  assign data     = drive_en ? rd_data : 'z;

endmodule
